uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver that succeeds the fixed 8-bit shift-register receiver. It adds configurable data width, parity and stop bits, a 2-flop input synchroniser, false-start rejection, and framing/parity/overrun error reporting. It sits between the rx_line pad and a valid/ready consumer such as a FIFO or register bank.

Parameters:
CLKS_PER_BIT, 5208, clk cycles per bit (>=8); counter width $clog2(CLKS_PER_BIT)
DATA_BITS, 8, data bits per frame, 5..9, LSB first
PARITY_MODE, 0, 0=none, 1=odd, 2=even
STOP_BITS, 1, 1 or 2 stop bits

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
rx_line  input  1  asynchronous serial input, idle high
rx_data  output  DATA_BITS  received word, valid while rx_valid=1
rx_valid  output  1  holding register full
rx_ready  input  1  consumer accepts rx_data when rx_valid&&rx_ready
frame_err  output  1  stop bit sampled low for the word in rx_data (qualified by rx_valid)
parity_err  output  1  parity mismatch for the word in rx_data (qualified by rx_valid); 0 when PARITY_MODE=0
overrun_err  output  1  one-cycle pulse: completed frame dropped because the holding register was full

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: rx_data=0, rx_valid=0, frame_err=0, parity_err=0, overrun_err=0. Synchroniser flops reset to 1. FSM goes to IDLE.
- Reset mid-frame aborts the frame with no output activity.
- Synchroniser: rx_s is rx_line after 2 flops. All sampling uses rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE: when rx_s=0, clear the counter and go to START.
- START: at count CLKS_PER_BIT/2-1 (mid start bit), sample the line.
  - If 1: false start, return to IDLE, no flags.
  - If 0: clear the counter and go to DATA.
- DATA: sample at count CLKS_PER_BIT-1, i.e. each bit centre. Shift right with the new bit entering the MSB, so bit 0 arrives first. After DATA_BITS samples go to PARITY if PARITY_MODE!=0, else STOP.
- PARITY: sample one bit. Mismatch sets the internal perr.
  - Odd: XOR of data bits and parity bit must be 1.
  - Even: that XOR must be 0.
- STOP: sample STOP_BITS bits. Any low sample sets the internal ferr.
- Frame completion: on the cycle after the last stop sample, the frame completes. No waiting for the end of the stop bit.
  - If rx_valid=0, or rx_valid=1 with rx_ready=1 (same-cycle consume): load rx_data, frame_err<=ferr, parity_err<=perr, rx_valid<=1.
  - Otherwise: discard the frame, keep the old rx_data/flags, pulse overrun_err for 1 cycle.
- After completion: go to IDLE if the last stop sample was 1; otherwise go to WAIT_IDLE.
- WAIT_IDLE (break/framing recovery): stay until rx_s=1, then go to IDLE.
- Handshake: rx_valid&&rx_ready with no simultaneous completion clears rx_valid next cycle. Completion and consume in the same cycle keeps rx_valid=1 with the new word. rx_data is stable while rx_valid=1 and not consumed.
- Latency: rx_valid rises 1 cycle after the last stop sample, which is 3 cycles of synchroniser plus FSM after the line edge.
- Internal counters wrap only via explicit clear. No counter overflow is possible for legal parameters.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each bit value (start check, data, parity, stop) is the 2-of-3 majority of rx_s at counts centre-1, centre, centre+1. The decision is made at centre+1, which delays every transition, and rx_valid, by 1 cycle.
- Undefined: single sample at centre, as described in Behaviour.

Test Plan:
- CLKS_PER_BIT=16, 8N1, send 0xA5, rx_ready=1 -> rx_data=0xA5, rx_valid high 1 cycle, frame_err=0, parity_err=0.
- rx_line low for 4 cycles then high -> no rx_valid, FSM back in IDLE; a following 0x3C frame is received correctly.
- PARITY_MODE=2, send 0x07 with parity bit 0 -> rx_data=0x07, parity_err=1. Repeat with parity bit 1 -> parity_err=0.
- Send 0x55 with stop bit 0, then hold the line low 40 cycles -> frame_err=1, no new start until the line returns high; a next 0x12 frame is received cleanly.
- rx_ready=0, send 0x11 then 0x22 -> overrun_err pulses once, rx_data stays 0x11. Then raise rx_ready -> consumed, rx_valid=0.
- Assert rst during DATA of a 0xFF frame -> all outputs 0; the next 0x81 frame is received correctly. Run with and without UART_RX_MAJORITY_EN, including a 1-cycle glitch at a bit centre (majority build must reject it).

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param: parametrised UART receiver with a 2-flop input synchroniser,
// false-start rejection, optional parity, 1 or 2 stop bits and
// framing/parity/overrun error reporting. A single holding register feeds a
// valid/ready consumer.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   defined   : every bit is the 2-of-3 majority of rx_s at centre-1, centre
//               and centre+1. The decision is taken at centre+1.
//   undefined : every bit is a single sample of rx_s at the bit centre.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   rx_line      asynchronous serial input, idle high
//   rx_data      received word, valid while rx_valid=1
//   rx_valid     holding register full
//   rx_ready     consumer accepts rx_data when rx_valid && rx_ready
//   frame_err    stop bit sampled low for the word in rx_data
//   parity_err   parity mismatch for the word in rx_data
//   overrun_err  one-cycle pulse: completed frame dropped, holding register full
module uart_rx_param #(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_MODE  = 0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_line,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 overrun_err
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BW = 4;
`ifdef UART_RX_MAJORITY_EN
  localparam int unsigned START_PT = CLKS_PER_BIT / 2;
`else
  localparam int unsigned START_PT = CLKS_PER_BIT / 2 - 1;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_IDLE} state_t;

  state_t               state;
  logic                 sync1;
  logic                 rx_s;
  logic [CW-1:0]        cnt;
  logic [BW-1:0]        bcnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 bit_val;
  logic                 bit_tick;

  // Two-flop synchroniser, idles high so reset does not look like a start bit
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= rx_line;
      rx_s  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist[1] = rx_s two cycles ago, hist[0] = one cycle ago
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // The start decision restarts cnt, so later decisions always land on CLKS_PER_BIT-1
  assign bit_tick = (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      bcnt        <= '0;
      shreg       <= '0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      frame_err   <= 1'b0;
      parity_err  <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      overrun_err <= 1'b0;
      // Consume; a completion in the same cycle overrides this below
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            cnt   <= '0;
            state <= START;
          end
        end

        START: begin
          if (cnt == CW'(START_PT)) begin
            cnt <= '0;
            if (bit_val) begin
              state <= IDLE;
            end else begin
              state <= DATA;
              bcnt  <= '0;
              perr  <= 1'b0;
              ferr  <= 1'b0;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_tick) begin
            cnt   <= '0;
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bcnt == BW'(DATA_BITS - 1)) begin
              bcnt  <= '0;
              state <= (PARITY_MODE != 0) ? PARITY : STOP;
            end else begin
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        PARITY: begin
          if (bit_tick) begin
            cnt   <= '0;
            bcnt  <= '0;
            // Odd expects XOR=1, even expects XOR=0
            perr  <= (^{shreg, bit_val}) ^ (PARITY_MODE == 1);
            state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_tick) begin
            cnt <= '0;
            if (bcnt == BW'(STOP_BITS - 1)) begin
              bcnt <= '0;
              if (!rx_valid || rx_ready) begin
                rx_data    <= shreg;
                frame_err  <= ferr | ~bit_val;
                parity_err <= perr;
                rx_valid   <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
              state <= bit_val ? IDLE : WAIT_IDLE;
            end else begin
              ferr <= ferr | ~bit_val;
              bcnt <= bcnt + BW'(1);
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        WAIT_IDLE: begin
          if (rx_s) state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
